operand_stage_reg: RTL and testbench
====================================

Name: operand_stage_reg

Overview:
- Parametrised operand pipeline stage between register-file read and ALU input; supersedes the fixed two-operand A/B latch.
- Carries NUM_OPS operands of WIDTH bits with a valid/ready handshake, optional skid buffer, synchronous flush and writeback forwarding.
- Held operands are refreshed by forwarding, so they never go stale while the stage is stalled.

Parameters:
WIDTH, 32, bits per operand
NUM_OPS, 2, number of operand channels
ADDR_W, 5, register-address width; address 0 is hardwired zero and is never forwarded
SKID, 1, 1 = two-entry skid buffer with in_ready independent of out_ready; 0 = single register, in_ready = !out_valid || out_ready

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
flush  in  1  synchronous discard of all held entries
in_valid  in  1  upstream operands valid
in_ready  out  1  stage can accept this cycle
in_data  in  NUM_OPS*WIDTH  operands; channel k at [k*WIDTH +: WIDTH]
in_addr  in  NUM_OPS*ADDR_W  source register address per channel
wb_en  in  1  register-file writeback strobe
wb_addr  in  ADDR_W  writeback destination
wb_data  in  WIDTH  writeback value
out_valid  out  1  out_data valid
out_ready  in  1  ALU consumes this cycle
out_data  out  NUM_OPS*WIDTH  registered operands to ALU

Behaviour:
- Reset (async): state EMPTY, out_valid=0, out_data=0, skid data/addr=0, in_ready=0 while reset is high. in_ready=1 on the first cycle after release.
- Accept = in_valid && in_ready. Consume = out_valid && out_ready.
- Latency: accepted operands appear on out_data, with out_valid=1, on the next rising edge. No combinational path from in_data to out_data.
- SKID=1 state machine (main register plus skid register; in_ready = state != FULL):
  - EMPTY: accept -> ONE, main <= in.
  - ONE: accept && consume -> ONE, main <= in. accept && !consume -> FULL, skid <= in. !accept && consume -> EMPTY. Otherwise hold.
  - FULL: in_ready=0. consume -> ONE, main <= skid. Otherwise hold.
- SKID=0: states EMPTY/ONE only. in_ready = !out_valid || out_ready (combinational from out_ready). Accept always loads main.
- Order is preserved; no entry is dropped or duplicated except by flush or reset.
- out_data is stable while out_valid && !out_ready.
- Forwarding, per channel k, applied independently:
  - Capture: if wb_en && wb_addr==in_addr[k] && wb_addr!=0, the captured value is wb_data, not in_data[k].
  - Held entries: each main/skid entry stores its channel addresses. If wb_en && wb_addr matches a held address (nonzero), that channel's value <= wb_data.
  - Skid->main move in the same cycle as a matching writeback: main receives wb_data.
  - Matching writeback wins over every other data source on that edge.
- Flush (sync, priority over everything except reset):
  - Next state EMPTY, out_valid=0.
  - An input accepted in the flush cycle is discarded.
  - Data registers keep their values (don't-care while invalid).
  - in_ready follows the pre-flush state during the flush cycle.
- A consume in the flush cycle is legal; downstream sees it as the final transfer.
- Reset mid-transfer aborts immediately; no partial state survives.

Test Plan:
- Reset then in_valid with ops {0x11111111, 0x22222222}, out_ready=1 -> out_valid=1 one cycle later, out_data matches; back-to-back stream of 8 entries at 1/cycle with no bubbles.
- SKID=1, out_ready=0, push A then B -> in_ready=0 after B (FULL). Raise out_ready -> A then B in order; in_ready returns 1 the cycle after A is consumed.
- SKID=0, out_ready=0 with one entry held -> in_ready=0. out_ready=1 the same cycle as in_valid -> simultaneous consume and accept, no gap.
- Forwarding:
  - Capture with in_addr ch0=5 and wb_en, wb_addr=5, wb_data=0xDEADBEEF -> out ch0=0xDEADBEEF, ch1 unchanged.
  - Entry stalled in skid with addr 7, then wb to 7 with 0x00000042 -> it emerges with 0x00000042.
  - wb to addr 0 -> no change.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and in-flight entries never appear.
- Assert reset asynchronously mid-stream between clock edges -> out_valid and out_data go to 0 immediately. After release the first new entry is delivered normally.

Source files
------------

// File: rtl/operand_stage_reg.sv
// Operand pipeline stage between register-file read and ALU input: NUM_OPS
// registered operands with valid/ready, optional skid entry, flush and writeback forwarding.
module operand_stage_reg #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 2,
  parameter int ADDR_W  = 5,
  parameter int SKID    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*WIDTH-1:0]  in_data,
  input  logic [NUM_OPS*ADDR_W-1:0] in_addr,
  input  logic                      wb_en,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [WIDTH-1:0]          wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OPS*WIDTH-1:0]  out_data
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [NUM_OPS*WIDTH-1:0]  r_main_data;
  logic [NUM_OPS*ADDR_W-1:0] r_main_addr;
  logic [NUM_OPS*WIDTH-1:0]  r_skid_data;
  logic [NUM_OPS*ADDR_W-1:0] r_skid_addr;
  logic [NUM_OPS*WIDTH-1:0]  w_in_f;
  logic [NUM_OPS*WIDTH-1:0]  w_main_f;
  logic [NUM_OPS*WIDTH-1:0]  w_skid_f;
  logic                      w_rdy;
  logic                      w_accept;
  logic                      w_consume;
  logic                      w_ld_main_in;
  logic                      w_ld_main_skid;
  logic                      w_ld_skid;

  // Replace every channel whose source register is being written back this cycle.
  function automatic logic [NUM_OPS*WIDTH-1:0] fwd(
    input logic [NUM_OPS*WIDTH-1:0]  d,
    input logic [NUM_OPS*ADDR_W-1:0] a,
    input logic                      en,
    input logic [ADDR_W-1:0]         wa,
    input logic [WIDTH-1:0]          wd
  );
    logic [NUM_OPS*WIDTH-1:0] r;
    r = d;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (en && (wa != '0) && (a[k*ADDR_W +: ADDR_W] == wa)) r[k*WIDTH +: WIDTH] = wd;
    end
    return r;
  endfunction

  assign w_in_f   = fwd(in_data, in_addr, wb_en, wb_addr, wb_data);
  assign w_main_f = fwd(r_main_data, r_main_addr, wb_en, wb_addr, wb_data);
  assign w_skid_f = fwd(r_skid_data, r_skid_addr, wb_en, wb_addr, wb_data);

  assign w_rdy     = (SKID != 0) ? (r_state != FULL) : ((r_state == EMPTY) || out_ready);
  assign in_ready  = !reset && w_rdy;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main_data;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;

  always_comb begin
    w_next         = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_next       = ONE;
          w_ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_consume) begin
          w_ld_main_in = 1'b1;
        end else if (w_accept && (SKID != 0)) begin
          w_next    = FULL;
          w_ld_skid = 1'b1;
        end else if (w_consume) begin
          w_next = EMPTY;
        end
      end
      FULL: begin
        if (w_consume) begin
          w_next         = ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: w_next = EMPTY;
    endcase
    // Flush drops everything held plus anything accepted this cycle.
    if (flush) begin
      w_next         = EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_main_data <= '0;
      r_main_addr <= '0;
      r_skid_data <= '0;
      r_skid_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_ld_main_in) begin
        r_main_data <= w_in_f;
        r_main_addr <= in_addr;
      end else if (w_ld_main_skid) begin
        r_main_data <= w_skid_f;
        r_main_addr <= r_skid_addr;
      end else begin
        r_main_data <= w_main_f;
      end
      if (w_ld_skid) begin
        r_skid_data <= w_in_f;
        r_skid_addr <= in_addr;
      end else begin
        r_skid_data <= w_skid_f;
      end
    end
  end

endmodule

// File: tb/tb_operand_stage_reg.sv
// Randomised scoreboard bench for operand_stage_reg: SKID=1 and SKID=0 instances
// share stimulus and are each checked against a queue-based reference model.
module tb_operand_stage_reg;

  localparam int W = 32;
  localparam int N = 2;
  localparam int A = 5;

  typedef struct {
    logic [N*W-1:0] d;
    logic [N*A-1:0] a;
  } ent_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N*A-1:0] in_addr = '0;
  logic           wb_en = 1'b0;
  logic [A-1:0]   wb_addr = '0;
  logic [W-1:0]   wb_data = '0;
  logic           out_ready = 1'b0;

  logic           in_ready1, out_valid1, in_ready0, out_valid0;
  logic [N*W-1:0] out_data1, out_data0;

  int   vectors = 0;
  int   errors = 0;
  ent_t q1[$];
  ent_t q0[$];

  always #5 clk = ~clk;

  operand_stage_reg #(.WIDTH(W), .NUM_OPS(N), .ADDR_W(A), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_addr(in_addr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
  );

  operand_stage_reg #(.WIDTH(W), .NUM_OPS(N), .ADDR_W(A), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_addr(in_addr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // A register-file write of a nonzero address overrides that operand wherever it is held.
  function automatic logic [N*W-1:0] fwd(input logic [N*W-1:0] d, input logic [N*A-1:0] a);
    logic [N*W-1:0] r;
    r = d;
    for (int k = 0; k < N; k++)
      if (wb_en && wb_addr != 0 && a[k*A +: A] == wb_addr) r[k*W +: W] = wb_data;
    return r;
  endfunction

  // Reference for the two-entry stage: check what is presented now, then predict the next edge.
  always @(negedge clk) begin
    bit   er;
    ent_t e;
    if (reset) begin
      chk("rst_ready1", in_ready1, 0);
      chk("rst_valid1", out_valid1, 0);
      chk("rst_data1", out_data1, 0);
      q1.delete();
    end else begin
      er = (q1.size() < 2);
      chk("in_ready1", in_ready1, er);
      chk("out_valid1", out_valid1, q1.size() != 0);
      if (q1.size() != 0) chk("out_data1", out_data1, q1[0].d);
      if (flush) q1.delete();
      else begin
        if (q1.size() != 0 && out_ready) void'(q1.pop_front());
        for (int j = 0; j < q1.size(); j++) begin
          e = q1[j]; e.d = fwd(e.d, e.a); q1[j] = e;
        end
        if (in_valid && er) begin
          e.d = fwd(in_data, in_addr); e.a = in_addr; q1.push_back(e);
        end
      end
    end
  end

  // Reference for the single-entry stage.
  always @(negedge clk) begin
    bit   er;
    ent_t e;
    if (reset) begin
      chk("rst_ready0", in_ready0, 0);
      chk("rst_valid0", out_valid0, 0);
      chk("rst_data0", out_data0, 0);
      q0.delete();
    end else begin
      er = (q0.size() == 0) || out_ready;
      chk("in_ready0", in_ready0, er);
      chk("out_valid0", out_valid0, q0.size() != 0);
      if (q0.size() != 0) chk("out_data0", out_data0, q0[0].d);
      if (flush) q0.delete();
      else begin
        if (q0.size() != 0 && out_ready) void'(q0.pop_front());
        for (int j = 0; j < q0.size(); j++) begin
          e = q0[j]; e.d = fwd(e.d, e.a); q0[j] = e;
        end
        if (in_valid && er) begin
          e.d = fwd(in_data, in_addr); e.a = in_addr; q0.push_back(e);
        end
      end
    end
  end

  task automatic cyc(input bit iv, input logic [W-1:0] d1, input logic [W-1:0] d0,
                     input logic [A-1:0] a1, input logic [A-1:0] a0, input bit ordy,
                     input bit wbe, input logic [A-1:0] wba, input logic [W-1:0] wbd,
                     input bit fl);
    in_valid  = iv;
    in_data   = {d1, d0};
    in_addr   = {a1, a0};
    out_ready = ordy;
    wb_en     = wbe;
    wb_addr   = wba;
    wb_data   = wbd;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cyc(1, 32'h22222222, 32'h11111111, 5'd2, 5'd1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 32'hA000 + i, 32'hB000 + i, 5'd9, 5'd10, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Fill with ready low, then drain in order.
    cyc(1, 32'hAAAA0001, 32'hAAAA0000, 5'd3, 5'd4, 0, 0, 0, 0, 0);
    cyc(1, 32'hBBBB0001, 32'hBBBB0000, 5'd3, 5'd4, 0, 0, 0, 0, 0);
    cyc(1, 32'hCCCC0001, 32'hCCCC0000, 5'd3, 5'd4, 0, 0, 0, 0, 0);
    cyc(1, 32'hCCCC0001, 32'hCCCC0000, 5'd3, 5'd4, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Capture-time forwarding on channel 0 only.
    cyc(1, 32'h12345678, 32'h00000000, 5'd6, 5'd5, 1, 1, 5'd5, 32'hDEADBEEF, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Entry stalled in the skid slot with address 7 picks up a later writeback.
    cyc(1, 32'h00000101, 32'h00000100, 5'd1, 5'd2, 0, 0, 0, 0, 0);
    cyc(1, 32'h00000201, 32'h00000200, 5'd3, 5'd7, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h00000042, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Writeback to address 0 never forwards.
    cyc(1, 32'h0000BEEF, 32'h0000CAFE, 5'd0, 5'd0, 1, 1, 5'd0, 32'h99999999, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Flush while full with a new input offered.
    cyc(1, 32'h1, 32'h2, 5'd1, 5'd1, 0, 0, 0, 0, 0);
    cyc(1, 32'h3, 32'h4, 5'd1, 5'd1, 0, 0, 0, 0, 0);
    cyc(1, 32'h5, 32'h6, 5'd1, 5'd1, 0, 0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Asynchronous reset between edges with entries held.
    cyc(1, 32'h7, 32'h8, 5'd1, 5'd1, 0, 0, 0, 0, 0);
    cyc(1, 32'h9, 32'hA, 5'd1, 5'd1, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_valid1", out_valid1, 0);
    chk("async_data1", out_data1, 0);
    chk("async_valid0", out_valid0, 0);
    chk("async_data0", out_data0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd2, 5'd3, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Randomised traffic with alternating backpressure phases.
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom,
          A'($urandom_range(0, 7)), A'($urandom_range(0, 7)),
          $urandom_range(0, 9) < (((i / 100) % 2) ? 8 : 3),
          $urandom_range(0, 9) < 3, A'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 99) < 3);
    end
    repeat (4) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
